// File: rtl/gtwizard_0_check_pkg.sv
// Shared types and widths for the GT link check sequencer.
package gtwizard_0_check_pkg;

  localparam int TIMER_W = 24;
  localparam int ERR_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GT_RST    = 3'd1,
    ST_WAIT_GT   = 3'd2,
    ST_CHK_RST   = 3'd3,
    ST_WAIT_LOCK = 3'd4,
    ST_RUN       = 3'd5,
    ST_DONE      = 3'd6
  } chk_state_e;

  // Error total accumulate that pins at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a, input logic [7:0] b);
    logic [ERR_W:0] s;
    s = {1'b0, a} + {{(ERR_W-7){1'b0}}, b};
    return s[ERR_W] ? {ERR_W{1'b1}} : s[ERR_W-1:0];
  endfunction

endpackage

// File: rtl/gtwizard_0_check_timer.sv
// Shared down-timer: load a value, count to zero, flag zero as expired.
module gtwizard_0_check_timer
  import gtwizard_0_check_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] value_i,
  output logic               expired_o
);

  logic [TIMER_W-1:0] cnt_q;

  // Reload wins; otherwise count down and park at zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)               cnt_q <= '0;
    else if (load_i)         cnt_q <= value_i;
    else if (cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/gtwizard_0_gt_check_sequencer.sv
// GT RX bring-up and link check sequencer: resets the GT and frame checker,
// waits for lock, runs a timed error-count window, retries on failure.
module gtwizard_0_gt_check_sequencer
  import gtwizard_0_check_pkg::*;
#(
  parameter int GT_RESET_CYCLES    = 16,
  parameter int CHECK_RESET_CYCLES = 8,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int TEST_CYCLES        = 1000000,
  parameter int MAX_RETRIES        = 3,
  parameter int ERROR_THRESHOLD    = 0
) (
  input  logic             USER_CLK,
  input  logic             SYSTEM_RESET,
  input  logic             START_IN,
  input  logic             ABORT_IN,
  input  logic             GT_RESET_DONE_IN,
  input  logic             TRACK_DATA_IN,
  input  logic [7:0]       ERROR_COUNT_IN,
  output logic             GT_RX_RESET_OUT,
  output logic             CHECK_RESET_OUT,
  output logic             BUSY_OUT,
  output logic             DONE_OUT,
  output logic             PASS_OUT,
  output logic [3:0]       ATTEMPT_COUNT_OUT,
  output logic [ERR_W-1:0] ERROR_TOTAL_OUT,
  output logic [2:0]       STATE_OUT
);

  // Timer holds N-1 on entry so a state with an N-cycle budget spends N cycles.
  localparam logic [TIMER_W-1:0] GT_LD   = TIMER_W'(GT_RESET_CYCLES - 1);
  localparam logic [TIMER_W-1:0] CHK_LD  = TIMER_W'(CHECK_RESET_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LD = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] RUN_LD  = TIMER_W'(TEST_CYCLES - 1);

  chk_state_e         state_q, state_d;
  // One extra bit so MAX_RETRIES=15 can reach a 16th attempt without wrapping.
  logic [4:0]         att_q, att_d;
  logic [7:0]         prev_q;
  logic [7:0]         delta;
  logic [ERR_W-1:0]   tot_run;
  logic               fail, pass_d;
  logic               tmr_load, tmr_exp;
  logic [TIMER_W-1:0] tmr_val;

  gtwizard_0_check_timer u_timer (
    .clk_i     (USER_CLK),
    .rst_i     (SYSTEM_RESET),
    .load_i    (tmr_load),
    .value_i   (tmr_val),
    .expired_o (tmr_exp)
  );

  // Next-state decision, attempt bookkeeping and timer reload on every state change.
  always_comb begin
    delta   = ERROR_COUNT_IN - prev_q;
    tot_run = sat_add(ERROR_TOTAL_OUT, delta);
    state_d = state_q;
    fail    = 1'b0;
    pass_d  = 1'b0;
    case (state_q)
      ST_IDLE:      if (START_IN) state_d = ST_GT_RST;
      ST_GT_RST:    if (tmr_exp) state_d = ST_WAIT_GT;
      ST_WAIT_GT:   if (GT_RESET_DONE_IN) state_d = ST_CHK_RST;
      ST_CHK_RST:   if (tmr_exp) state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: if (TRACK_DATA_IN) state_d = ST_RUN;
                    else if (tmr_exp) fail = 1'b1;
      // Failure outranks the window end landing on the same cycle.
      ST_RUN:       if (!TRACK_DATA_IN || 32'(tot_run) > ERROR_THRESHOLD) fail = 1'b1;
                    else if (tmr_exp) begin
                      state_d = ST_DONE;
                      pass_d  = 1'b1;
                    end
      ST_DONE:      if (!START_IN) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    if (fail) state_d = (32'(att_q) <= MAX_RETRIES) ? ST_GT_RST : ST_DONE;
    if (ABORT_IN && state_q != ST_IDLE && state_q != ST_DONE) begin
      state_d = ST_DONE;
      pass_d  = 1'b0;
      fail    = 1'b0;
    end

    att_d = att_q;
    if (state_q == ST_IDLE && state_d == ST_GT_RST) att_d = 5'd1;
    else if (fail && state_d == ST_GT_RST)          att_d = att_q + 5'd1;

    tmr_load = (state_d != state_q);
    case (state_d)
      ST_GT_RST:    tmr_val = GT_LD;
      ST_CHK_RST:   tmr_val = CHK_LD;
      ST_WAIT_LOCK: tmr_val = LOCK_LD;
      ST_RUN:       tmr_val = RUN_LD;
      default:      tmr_val = '0;
    endcase
  end

  // State plus all outputs, each registered from the decided next state.
  always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
    if (SYSTEM_RESET) begin
      state_q           <= ST_IDLE;
      att_q             <= '0;
      prev_q            <= '0;
      GT_RX_RESET_OUT   <= 1'b0;
      CHECK_RESET_OUT   <= 1'b1;
      BUSY_OUT          <= 1'b0;
      DONE_OUT          <= 1'b0;
      PASS_OUT          <= 1'b0;
      ATTEMPT_COUNT_OUT <= '0;
      ERROR_TOTAL_OUT   <= '0;
    end else begin
      state_q           <= state_d;
      att_q             <= att_d;
      ATTEMPT_COUNT_OUT <= (att_d > 5'd15) ? 4'hF : att_d[3:0];
      GT_RX_RESET_OUT   <= (state_d == ST_GT_RST);
      CHECK_RESET_OUT   <= !(state_d == ST_WAIT_LOCK || state_d == ST_RUN);
      BUSY_OUT          <= (state_d != ST_IDLE && state_d != ST_DONE);
      if (state_q == ST_IDLE && state_d == ST_GT_RST) begin
        DONE_OUT <= 1'b0;
        PASS_OUT <= 1'b0;
      end
      if (state_q != ST_DONE && state_d == ST_DONE) begin
        DONE_OUT <= 1'b1;
        PASS_OUT <= pass_d;
      end
      // Baseline the checker counter on RUN entry, then integrate deltas.
      if (state_q == ST_WAIT_LOCK && state_d == ST_RUN) begin
        prev_q          <= ERROR_COUNT_IN;
        ERROR_TOTAL_OUT <= '0;
      end else if (state_q == ST_RUN) begin
        prev_q          <= ERROR_COUNT_IN;
        ERROR_TOTAL_OUT <= tot_run;
      end
    end
  end

  assign STATE_OUT = state_q;

endmodule

// File: tb/tb_gtwizard_0_gt_check_sequencer.sv
// Bench for the GT check sequencer: two instances (generous retries / tight
// retries), each shadowed by a phase-and-elapsed-cycle model.
module tb_gtwizard_0_gt_check_sequencer;

  localparam int GTC = 4, CHKC = 3, TESTC = 40;
  localparam int A_LOCK = 200, A_MR = 3, A_TH = 300;
  localparam int B_LOCK = 20,  B_MR = 1, B_TH = 0;

  typedef struct {
    int ph; int cnt; int att; int tot; int prev; bit done; bit pass;
  } mdl_t;

  logic clk, rst, abort, gdone;
  logic start_a, trk_a, start_b, trk_b;
  logic [7:0] ec_a, ec_b;
  logic gtr_a, chk_a, busy_a, done_a, pass_a, gtr_b, chk_b, busy_b, done_b, pass_b;
  logic [3:0] att_a, att_b;
  logic [15:0] tot_a, tot_b;
  logic [2:0] st_a, st_b;

  int checks = 0, failures = 0;
  int gt_pulses = 0, lock_exp = 0;
  logic gtr_a_prev = 1'b0;
  logic [2:0] st_b_prev = 3'd0;
  mdl_t ma, mb;

  gtwizard_0_gt_check_sequencer #(.GT_RESET_CYCLES(GTC), .CHECK_RESET_CYCLES(CHKC),
    .LOCK_TIMEOUT(A_LOCK), .TEST_CYCLES(TESTC), .MAX_RETRIES(A_MR), .ERROR_THRESHOLD(A_TH)) dut_a (
    .USER_CLK(clk), .SYSTEM_RESET(rst), .START_IN(start_a), .ABORT_IN(abort),
    .GT_RESET_DONE_IN(gdone), .TRACK_DATA_IN(trk_a), .ERROR_COUNT_IN(ec_a),
    .GT_RX_RESET_OUT(gtr_a), .CHECK_RESET_OUT(chk_a), .BUSY_OUT(busy_a), .DONE_OUT(done_a),
    .PASS_OUT(pass_a), .ATTEMPT_COUNT_OUT(att_a), .ERROR_TOTAL_OUT(tot_a), .STATE_OUT(st_a));

  gtwizard_0_gt_check_sequencer #(.GT_RESET_CYCLES(GTC), .CHECK_RESET_CYCLES(CHKC),
    .LOCK_TIMEOUT(B_LOCK), .TEST_CYCLES(TESTC), .MAX_RETRIES(B_MR), .ERROR_THRESHOLD(B_TH)) dut_b (
    .USER_CLK(clk), .SYSTEM_RESET(rst), .START_IN(start_b), .ABORT_IN(abort),
    .GT_RESET_DONE_IN(gdone), .TRACK_DATA_IN(trk_b), .ERROR_COUNT_IN(ec_b),
    .GT_RX_RESET_OUT(gtr_b), .CHECK_RESET_OUT(chk_b), .BUSY_OUT(busy_b), .DONE_OUT(done_b),
    .PASS_OUT(pass_b), .ATTEMPT_COUNT_OUT(att_b), .ERROR_TOTAL_OUT(tot_b), .STATE_OUT(st_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic mdl_t mdl_rst();
    mdl_t m;
    m.ph = 0; m.cnt = 0; m.att = 0; m.tot = 0; m.prev = 0; m.done = 0; m.pass = 0;
    return m;
  endfunction

  // Phase model: phases tracked by elapsed cycles; a phase with budget N is left on its Nth cycle.
  function automatic mdl_t step(mdl_t m, bit start, bit ab, bit gd, bit track, int ec,
                                int lockc, int mr, int th);
    mdl_t n;
    bit fail;
    n = m; fail = 0;
    n.cnt = m.cnt + 1;
    if (m.ph == 5) begin
      n.tot = m.tot + ((ec - m.prev) & 255);
      if (n.tot > 65535) n.tot = 65535;
      n.prev = ec;
    end
    if (ab && m.ph != 0 && m.ph != 6) begin
      n.ph = 6; n.done = 1; n.pass = 0;
    end else begin
      case (m.ph)
        0: if (start) begin n.ph = 1; n.att = 1; n.done = 0; n.pass = 0; end
        1: if (n.cnt == GTC) n.ph = 2;
        2: if (gd) n.ph = 3;
        3: if (n.cnt == CHKC) n.ph = 4;
        4: if (track) begin n.ph = 5; n.prev = ec; n.tot = 0; end
           else if (n.cnt == lockc) fail = 1;
        5: if (!track || n.tot > th) fail = 1;
           else if (n.cnt == TESTC) begin n.ph = 6; n.done = 1; n.pass = 1; end
        6: if (!start) n.ph = 0;
        default: n.ph = 0;
      endcase
      if (fail) begin
        if (m.att <= mr) begin n.att = m.att + 1; n.ph = 1; end
        else begin n.ph = 6; n.done = 1; n.pass = 0; end
      end
    end
    if (n.ph != m.ph) n.cnt = 0;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= mdl_rst();
      mb <= mdl_rst();
    end else begin
      ma <= step(ma, start_a, abort, gdone, trk_a, int'(ec_a), A_LOCK, A_MR, A_TH);
      mb <= step(mb, start_b, abort, gdone, trk_b, int'(ec_b), B_LOCK, B_MR, B_TH);
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input string p, input mdl_t m, input logic [2:0] st, input logic gtr,
                          input logic chk, input logic busy, input logic done, input logic pass,
                          input logic [3:0] att, input logic [15:0] tot);
    cmp({p, ".state"}, 32'(st), 32'(m.ph));
    cmp({p, ".gt_rst"}, 32'(gtr), 32'(m.ph == 1));
    cmp({p, ".chk_rst"}, 32'(chk), 32'(!(m.ph == 4 || m.ph == 5)));
    cmp({p, ".busy"}, 32'(busy), 32'(m.ph >= 1 && m.ph <= 5));
    cmp({p, ".done"}, 32'(done), 32'(m.done));
    cmp({p, ".pass"}, 32'(pass), 32'(m.pass));
    cmp({p, ".attempt"}, 32'(att), 32'((m.att > 15) ? 15 : m.att));
    cmp({p, ".err_total"}, 32'(tot), 32'(m.tot));
  endtask

  // Every-cycle compare of both instances against their models, plus event counters.
  always @(negedge clk) begin
    cmp_inst("A", ma, st_a, gtr_a, chk_a, busy_a, done_a, pass_a, att_a, tot_a);
    cmp_inst("B", mb, st_b, gtr_b, chk_b, busy_b, done_b, pass_b, att_b, tot_b);
    if (gtr_a && !gtr_a_prev) gt_pulses <= gt_pulses + 1;
    if (st_b_prev == 3'd4 && st_b != 3'd4 && st_b != 3'd5) lock_exp <= lock_exp + 1;
    gtr_a_prev <= gtr_a;
    st_b_prev  <= st_b;
  end

  task automatic wait_st(input bit b, input logic [2:0] s, input int budget, input string nm);
    int n;
    n = 0;
    while (((b ? st_b : st_a) != s) && n < budget) begin
      @(negedge clk);
      n++;
    end
    cmp({nm, ".reach"}, 32'(b ? st_b : st_a), 32'(s));
  endtask

  task automatic pulse_start(input bit b);
    @(negedge clk);
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    if (b) start_b = 1'b0; else start_a = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int p0, l0;
    rst = 1'b1; abort = 1'b0; gdone = 1'b0;
    start_a = 1'b0; trk_a = 1'b0; ec_a = 8'd0;
    start_b = 1'b0; trk_b = 1'b0; ec_b = 8'd0;
    repeat (3) @(negedge clk);
    cmp("reset.chk_a", 32'(chk_a), 32'd1);
    cmp("reset.state_a", 32'(st_a), 32'd0);
    rst = 1'b0;

    // Nominal: GT done 5 cycles into GT_RST, lock 100 cycles after release.
    pulse_start(1'b0);
    cmp("nom.gt_rst_first", 32'(gtr_a), 32'd1);
    repeat (4) @(negedge clk);
    gdone = 1'b1;
    wait_st(1'b0, 3'd4, 50, "nom.lock");
    repeat (100) @(negedge clk);
    trk_a = 1'b1;
    wait_st(1'b0, 3'd6, 200, "nom.done");
    cmp("nom.done", 32'(done_a), 32'd1);
    cmp("nom.pass", 32'(pass_a), 32'd1);
    cmp("nom.attempt", 32'(att_a), 32'd1);
    cmp("nom.err_total", 32'(tot_a), 32'd0);
    trk_a = 1'b0;
    @(negedge clk);

    // Counter wrap: 250 -> 253 -> 0 -> 4 totals 10 errors.
    ec_a = 8'd250;
    pulse_start(1'b0);
    wait_st(1'b0, 3'd4, 50, "wrap.lock");
    trk_a = 1'b1;
    wait_st(1'b0, 3'd5, 5, "wrap.run");
    @(negedge clk); ec_a = 8'd253;
    @(negedge clk); ec_a = 8'd0;
    @(negedge clk); ec_a = 8'd4;
    wait_st(1'b0, 3'd6, 100, "wrap.done");
    cmp("wrap.err_total", 32'(tot_a), 32'd10);
    cmp("wrap.pass", 32'(pass_a), 32'd1);
    trk_a = 1'b0;
    @(negedge clk);

    // Retry: link drops in RUN on attempts 1 and 2, holds on attempt 3.
    p0 = gt_pulses;
    pulse_start(1'b0);
    for (int k = 0; k < 3; k++) begin
      wait_st(1'b0, 3'd4, 100, "retry.lock");
      repeat (10) @(negedge clk);
      trk_a = 1'b1;
      wait_st(1'b0, 3'd5, 5, "retry.run");
      if (k < 2) begin
        repeat (5) @(negedge clk);
        trk_a = 1'b0;
      end
    end
    wait_st(1'b0, 3'd6, 100, "retry.done");
    @(negedge clk);
    cmp("retry.pass", 32'(pass_a), 32'd1);
    cmp("retry.attempt", 32'(att_a), 32'd3);
    cmp("retry.gt_pulses", 32'(gt_pulses - p0), 32'd3);
    trk_a = 1'b0;
    @(negedge clk);

    // Abort in RUN lands in DONE on the next cycle.
    pulse_start(1'b0);
    wait_st(1'b0, 3'd4, 50, "abort.lock");
    trk_a = 1'b1;
    wait_st(1'b0, 3'd5, 5, "abort.run");
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    cmp("abort.state", 32'(st_a), 32'd6);
    cmp("abort.pass", 32'(pass_a), 32'd0);
    cmp("abort.chk_rst", 32'(chk_a), 32'd1);
    trk_a = 1'b0;
    @(negedge clk);

    // Reset mid-run: outputs fall to reset values without a clock edge.
    pulse_start(1'b0);
    wait_st(1'b0, 3'd4, 50, "rstrun.lock");
    trk_a = 1'b1;
    wait_st(1'b0, 3'd5, 5, "rstrun.run");
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    cmp("rstrun.state", 32'(st_a), 32'd0);
    cmp("rstrun.chk_rst", 32'(chk_a), 32'd1);
    cmp("rstrun.busy", 32'(busy_a), 32'd0);
    cmp("rstrun.done", 32'(done_a), 32'd0);
    cmp("rstrun.attempt", 32'(att_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    trk_a = 1'b0;

    // START held through DONE must not retrigger.
    @(negedge clk);
    start_a = 1'b1;
    wait_st(1'b0, 3'd4, 50, "hold.lock");
    trk_a = 1'b1;
    wait_st(1'b0, 3'd6, 100, "hold.done");
    repeat (10) @(negedge clk);
    cmp("hold.stay_done", 32'(st_a), 32'd6);
    start_a = 1'b0;
    trk_a = 1'b0;
    repeat (4) @(negedge clk);
    cmp("hold.idle", 32'(st_a), 32'd0);
    cmp("hold.busy", 32'(busy_a), 32'd0);

    // Exhaustion: no lock ever, one retry allowed -> two lock timeouts then fail.
    l0 = lock_exp;
    pulse_start(1'b1);
    wait_st(1'b1, 3'd6, 400, "exh.done");
    @(negedge clk);
    cmp("exh.done", 32'(done_b), 32'd1);
    cmp("exh.pass", 32'(pass_b), 32'd0);
    cmp("exh.attempt", 32'(att_b), 32'd2);
    cmp("exh.timeouts", 32'(lock_exp - l0), 32'd2);
    @(negedge clk);

    // Threshold 0: a single error fails each attempt.
    ec_b = 8'd7;
    pulse_start(1'b1);
    wait_st(1'b1, 3'd4, 50, "thr.lock");
    trk_b = 1'b1;
    wait_st(1'b1, 3'd5, 5, "thr.run1");
    @(negedge clk); ec_b = 8'd8;
    wait_st(1'b1, 3'd1, 5, "thr.retry");
    wait_st(1'b1, 3'd5, 50, "thr.run2");
    @(negedge clk); ec_b = 8'd9;
    wait_st(1'b1, 3'd6, 10, "thr.done");
    cmp("thr.pass", 32'(pass_b), 32'd0);
    cmp("thr.attempt", 32'(att_b), 32'd2);
    cmp("thr.err_total", 32'(tot_b), 32'd1);
    trk_b = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
